// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master slice.
//   SPI_DATA_W        default transfer word width
//   spi_xfer_state_t  transfer controller state encoding
package spi_pkg;

  localparam int SPI_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } spi_xfer_state_t;

endpackage

// File: rtl/spi_xfer.sv
// SPI mode 0 transfer controller. Drives the SCK generator enable, consumes
// its rise/fall strobes, serialises tx_data on mosi and deserialises miso.
// Optional build macro SPI_XFER_LSB_FIRST_EN selects LSB-first bit order;
// the default build is MSB-first.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, tx_data    one-cycle request and word to send (sampled in IDLE)
//   rx_data, done     received word and its one-cycle update pulse
//   busy              transfer in progress
//   sck_en            enable to the SCK generator
//   sck_rise/sck_fall strobes from the SCK generator
//   ss_n, mosi, miso  SPI bus
//
// state | meaning
// IDLE  | ss_n high, waiting for start
// SETUP | ss_n low, first mosi bit settling before SCK runs
// SHIFT | SCK running: sample on rise, advance mosi on fall
// HOLD  | SCK stopped, ss_n still low for one cycle before release
module spi_xfer
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              sck_en,
  input  logic              sck_rise,
  input  logic              sck_fall,
  output logic              ss_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W);

  spi_xfer_state_t   state_q, state_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              ss_n_q, ss_n_d;
  logic              sck_en_q, sck_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mosi_q, mosi_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      ss_n_q    <= 1'b1;
      sck_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      ss_n_q    <= ss_n_d;
      sck_en_q  <= sck_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mosi_q    <= mosi_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    ss_n_d    = ss_n_q;
    sck_en_d  = sck_en_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    mosi_d    = mosi_q;

    case (state_q)
      IDLE: begin
        ss_n_d   = 1'b1;
        sck_en_d = 1'b0;
        if (start) begin
          tx_sh_d   = tx_data;
          bit_cnt_d = '0;
          ss_n_d    = 1'b0;
          busy_d    = 1'b1;
`ifdef SPI_XFER_LSB_FIRST_EN
          mosi_d    = tx_data[0];
`else
          mosi_d    = tx_data[DATA_W-1];
`endif
          state_d   = SETUP;
        end
      end

      SETUP: begin
        sck_en_d = 1'b1;
        state_d  = SHIFT;
      end

      SHIFT: begin
        // Rise wins if both strobes ever arrive together.
        if (sck_rise) begin
`ifdef SPI_XFER_LSB_FIRST_EN
          rx_sh_d = {miso, rx_sh_q[DATA_W-1:1]};
`else
          rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
`endif
          if (bit_cnt_q != CNT_LAST) bit_cnt_d = bit_cnt_q + CW'(1);
        end else if (sck_fall) begin
          if (bit_cnt_q == CNT_LAST) begin
            sck_en_d = 1'b0;
            state_d  = HOLD;
          end else begin
            // Rotate rather than zero-fill: the wrapped bit is never sent,
            // and every register bit stays live.
`ifdef SPI_XFER_LSB_FIRST_EN
            tx_sh_d = {tx_sh_q[0], tx_sh_q[DATA_W-1:1]};
            mosi_d  = tx_sh_q[1];
`else
            tx_sh_d = {tx_sh_q[DATA_W-2:0], tx_sh_q[DATA_W-1]};
            mosi_d  = tx_sh_q[DATA_W-2];
`endif
          end
        end
      end

      HOLD: begin
        rx_data_d = rx_sh_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        ss_n_d    = 1'b1;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sck_en  = sck_en_q;
  assign ss_n    = ss_n_q;
  assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_xfer.sv
// Bench for spi_xfer: behavioural SCK generator, loopback / slave-model miso,
// and a scoreboard of expected mosi bits and received words.
module tb_spi_xfer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       busy, done, sck_en, ss_n, mosi;
  logic       sck_rise, sck_fall, miso;

  logic       gen_rise = 1'b0, gen_fall = 1'b0, sck_lvl = 1'b0;
  logic       frc_rise = 1'b0, frc_fall = 1'b0, miso_rand = 1'b0;
  int         div = 0;
  int         baud = 0;
  int         miso_mode = 0;   // 0 loopback, 1 slave model, 2 random
  logic [7:0] slv = 8'h00;

  int chk_cnt = 0;
  int err_cnt = 0;
  int rise_cnt = 0;
  int done_cnt = 0;

  logic       bitq[$];
  logic [7:0] rxq[$];

  always #5 clk = ~clk;

  spi_xfer #(.DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .tx_data  (tx_data),
    .rx_data  (rx_data),
    .busy     (busy),
    .done     (done),
    .sck_en   (sck_en),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .miso     (miso)
  );

  assign sck_rise = gen_rise | frc_rise;
  assign sck_fall = gen_fall | frc_fall;
`ifdef SPI_XFER_LSB_FIRST_EN
  assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1) ? slv[0] : miso_rand;
`else
  assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1) ? slv[7] : miso_rand;
`endif

  // SCK generator: half period of baud+1 clocks, one-cycle strobes.
  always @(posedge clk) begin
    if (rst || !sck_en) begin
      div <= 0; sck_lvl <= 1'b0; gen_rise <= 1'b0; gen_fall <= 1'b0;
    end else if (div == baud) begin
      div <= 0; sck_lvl <= ~sck_lvl; gen_rise <= ~sck_lvl; gen_fall <= sck_lvl;
    end else begin
      div <= div + 1; gen_rise <= 1'b0; gen_fall <= 1'b0;
    end
  end

  // Monitor: pops expected bits on each enabled rise, expected word on done.
  always @(negedge clk) begin
    logic       eb;
    logic [7:0] ew;
    logic       have;
    if (!rst) begin
      if (sck_rise && sck_en) begin
        rise_cnt++;
        if (bitq.size() > 0) begin
          eb = bitq.pop_front();
          chk_cnt++;
          assert (mosi === eb) else begin
            err_cnt++;
            $error("FAIL mosi_bit observed=%b expected=%b", mosi, eb);
          end
        end
      end
      if (sck_fall && sck_en) begin
`ifdef SPI_XFER_LSB_FIRST_EN
        slv = {1'b0, slv[7:1]};
`else
        slv = {slv[6:0], 1'b0};
`endif
      end
      if (done) begin
        done_cnt++;
        have = (rxq.size() > 0);
        ew = have ? rxq.pop_front() : 8'h00;
        chk_cnt++;
        assert (have && rx_data === ew) else begin
          err_cnt++;
          $error("FAIL rx_word observed=%h expected=%h queued=%0d", rx_data, ew, have);
        end
      end
    end
  end

  function automatic logic exp_bit(logic [7:0] w, int i);
`ifdef SPI_XFER_LSB_FIRST_EN
    return w[i];
`else
    return w[7-i];
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_xfer(logic [7:0] txw, logic [7:0] rxw);
    for (int i = 0; i < 8; i++) bitq.push_back(exp_bit(txw, i));
    rxq.push_back(rxw);
  endtask

  task automatic pulse_start(logic [7:0] w);
    start = 1'b1; tx_data = w;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(string tag, int limit);
    int base = done_cnt;
    int c = 0;
    while (done_cnt == base && c < limit) begin tick(); c++; end
    check({tag, "_timeout"}, 32'(done_cnt > base), 32'd1);
  endtask

  task automatic wait_rises(string tag, int n, int limit);
    int c = 0;
    while (rise_cnt < n && c < limit) begin tick(); c++; end
    check({tag, "_timeout"}, 32'(rise_cnt >= n), 32'd1);
  endtask

  initial begin
    logic [7:0] r_hold;
    logic       m_hold;
    int         d0, c;

    repeat (3) tick();
    check("rst_ss_n", 32'(ss_n), 32'd1);
    check("rst_sck_en", 32'(sck_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_rx", 32'(rx_data), 32'd0);
    rst = 1'b0;
    tick();

    // 1: loopback 0xA5, baud 2
    baud = 2; miso_mode = 0; rise_cnt = 0;
    push_xfer(8'hA5, 8'hA5);
    d0 = done_cnt;
    pulse_start(8'hA5);
    check("t1_ss_n_low", 32'(ss_n), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    wait_done("t1", 200);
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_ss_n_after", 32'(ss_n), 32'd1);
    repeat (10) tick();
    check("t1_rises", 32'(rise_cnt), 32'd8);
    check("t1_done_count", 32'(done_cnt - d0), 32'd1);
    check("t1_rx_hold", 32'(rx_data), 32'hA5);

    // 2: slave model returns 0x3C, tx 0xC3, baud 0
    baud = 0; miso_mode = 1; slv = 8'h3C; rise_cnt = 0;
    push_xfer(8'hC3, 8'h3C);
    pulse_start(8'hC3);
    wait_done("t2", 100);
    repeat (3) tick();
    check("t2_rises", 32'(rise_cnt), 32'd8);

    // 3: start while busy is ignored
    baud = 1; miso_mode = 0; rise_cnt = 0;
    push_xfer(8'h12, 8'h12);
    d0 = done_cnt;
    pulse_start(8'h12);
    wait_rises("t3", 3, 100);
    pulse_start(8'hFF);
    wait_done("t3", 100);
    repeat (40) tick();
    check("t3_single_done", 32'(done_cnt - d0), 32'd1);
    check("t3_ss_n_idle", 32'(ss_n), 32'd1);

    // 4: reset after the 4th rise
    baud = 1; rise_cnt = 0;
    push_xfer(8'h99, 8'h99);
    d0 = done_cnt;
    pulse_start(8'h99);
    wait_rises("t4", 4, 100);
    rst = 1'b1;
    bitq.delete(); rxq.delete();
    tick();
    check("t4_ss_n", 32'(ss_n), 32'd1);
    check("t4_sck_en", 32'(sck_en), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_rx_clr", 32'(rx_data), 32'd0);
    check("t4_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (30) tick();
    check("t4_no_done", 32'(done_cnt - d0), 32'd0);

    // 5: back-to-back around the done cycle
    baud = 1; rise_cnt = 0;
    push_xfer(8'h66, 8'h66);
    d0 = done_cnt;
    pulse_start(8'h66);
    c = 0;
    while (!(rise_cnt >= 8 && sck_en === 1'b0) && c < 100) begin tick(); c++; end
    check("t5_hold_timeout", 32'(c < 100), 32'd1);
    start = 1'b1; tx_data = 8'hFF;     // sampled while still in HOLD
    tick();
    check("t5_done", 32'(done), 32'd1);
    check("t5_ss_n_gap", 32'(ss_n), 32'd1);
    check("t5_busy_gap", 32'(busy), 32'd0);
    tx_data = 8'h5A;
    push_xfer(8'h5A, 8'h5A);
    tick();                            // accepted in IDLE
    start = 1'b0;
    check("t5_ss_n_low", 32'(ss_n), 32'd0);
    check("t5_busy", 32'(busy), 32'd1);
    wait_done("t5", 100);
    repeat (3) tick();
    check("t5_done_count", 32'(done_cnt - d0), 32'd2);
    check("t5_rx", 32'(rx_data), 32'h5A);

    // 6: strobes and miso toggling while idle
    miso_mode = 2;
    r_hold = rx_data; m_hold = mosi; d0 = done_cnt;
    for (int i = 0; i < 16; i++) begin
      frc_rise = i[0]; frc_fall = ~i[0]; miso_rand = 1'($urandom_range(0, 1));
      tick();
    end
    frc_rise = 1'b0; frc_fall = 1'b0;
    repeat (3) tick();
    check("t6_rx", 32'(rx_data), 32'(r_hold));
    check("t6_mosi", 32'(mosi), 32'(m_hold));
    check("t6_ss_n", 32'(ss_n), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_no_done", 32'(done_cnt - d0), 32'd0);
    check("t6_queues", 32'(bitq.size() + rxq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/spi_xfer.md
Name: spi_xfer

Overview:
- SPI master transfer controller, mode 0 (CPOL=0, CPHA=0).
- Sits directly downstream of the SCK generator. It drives that generator's enable and consumes its sck_rise/sck_fall strobes.
- Serialises one DATA_W-bit word onto mosi while deserialising miso. It manages ss_n and gives the Wishbone register block a start/busy/done handshake.

Parameters:
- DATA_W, 8, transfer word width in bits (supported range 2..32).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- tx_data  in  DATA_W  word to transmit; latched on accepted start
- rx_data  out  DATA_W  last received word; held until the next completion
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse when rx_data is updated
- sck_en  out  1  enable to SCK generator (its en input)
- sck_rise  in  1  SCK generator rising-edge strobe
- sck_fall  in  1  SCK generator falling-edge strobe
- ss_n  out  1  slave select, active low
- mosi  out  1  serial data out
- miso  in  1  serial data in

Behaviour:
- Clock and reset: clk, rising edge; reset rst, synchronous, active-high.
- Reset values: state=IDLE, ss_n=1, sck_en=0, busy=0, done=0, mosi=0, rx_data=0, bit_cnt=0, shift regs=0.
- Reset mid-transfer: next edge returns to IDLE with the values above. No done pulse; rx_data is cleared.
- States: IDLE, SETUP, SHIFT, HOLD; all outputs registered.
- IDLE:
  - ss_n=1, sck_en=0.
  - On start=1: tx_sh<=tx_data, bit_cnt<=0, ss_n<=0, busy<=1, mosi<=tx_data MSB; go to SETUP.
- SETUP:
  - Exactly 1 cycle; mosi is stable at least 1 clk before SCK is enabled.
  - Next: sck_en<=1, go to SHIFT.
- SHIFT, on sck_rise:
  - rx_sh<={rx_sh[DATA_W-2:0],miso}.
  - bit_cnt<=bit_cnt+1; bit_cnt is width clog2(DATA_W+1) and never wraps.
- SHIFT, on sck_fall:
  - If bit_cnt==DATA_W: sck_en<=0, go to HOLD. mosi is unchanged.
  - Else: tx_sh shifts left 1 and mosi<=next bit.
- HOLD:
  - 1 cycle with ss_n still 0.
  - Then rx_data<=rx_sh, done<=1 for one cycle, busy<=0, ss_n<=1; go to IDLE.
- Ignored inputs:
  - start while busy is ignored; there is no queuing.
  - tx_data changes after acceptance are ignored.
  - sck_rise/sck_fall outside SHIFT are ignored.
- Simultaneous sck_rise and sck_fall: cannot be produced by the generator. If both occur, rise is processed and fall is dropped.
- Transfer length: exactly DATA_W rising edges per transfer. The last bit is sampled on the DATA_W-th rise. sck idles low after sck_en drops.
- done and a new start:
  - done and the return to IDLE occur on the same edge.
  - start asserted in that same cycle is ignored because the state is not yet IDLE.
  - start asserted the following cycle is accepted.

Optional Feature:
- Macro: SPI_XFER_LSB_FIRST_EN.
- Defined: LSB-first order.
  - mosi initial bit = tx_data[0]; tx_sh shifts right.
  - rx_sh shifts in from the MSB: {miso,rx_sh[DATA_W-1:1]}.
- Undefined (default): MSB-first as described in Behaviour.
- Handshake timing is identical either way.

Decomposition:
- Shared package spi_pkg holds:
  - SPI_DATA_W default constant (8).
  - State encoding typedef spi_xfer_state_t: IDLE=2'd0, SETUP=2'd1, SHIFT=2'd2, HOLD=2'd3.
- No sub-module; bit counter and shift registers are inline.
- The SPI top level instantiates spi_xfer alongside the SCK generator and wires sck_en to its en.

Test Plan:
1. Loopback: mosi tied to miso, baudrate=2, tx_data=0xA5, start pulse.
   - ss_n falls 1 cycle after start; exactly 8 sck_rise strobes.
   - done single pulse; rx_data=0xA5; busy low and ss_n high after done.
2. Pattern order: miso driven from a bench shift model returning 0x3C, tx_data=0xC3, baudrate=0.
   - rx_data=0x3C and captured mosi bits = 1,1,0,0,0,0,1,1.
   - With SPI_XFER_LSB_FIRST_EN: mosi bits = 1,1,0,0,0,0,1,1 reversed order check (LSB first), rx_data=0x3C.
3. Start while busy: second start with tx_data=0xFF mid-transfer of 0x12.
   - Ignored; only one done; loopback rx_data=0x12.
4. Reset mid-transfer: rst after the 4th sck_rise.
   - Next cycle: ss_n=1, sck_en=0, busy=0, rx_data=0, no done pulse.
5. Back-to-back: start in the done cycle is ignored; start the next cycle (tx_data=0x5A) is accepted.
   - Second done with rx_data=0x5A; ss_n high for at least 1 cycle between transfers.
6. Idle immunity: toggle sck_rise/sck_fall and miso while IDLE.
   - rx_data, mosi, ss_n and busy unchanged.
